// File: rtl/sram10t_access_ctrl.sv
// sram10t_access_ctrl
//   Sequencing controller for a single-ended 10T SRAM word array. It accepts
//   one read or write request at a time over a valid/ready handshake. It then
//   drives precharge, read/write wordlines, write bitlines, write assist and
//   sense strobe so that they never overlap. Read data is returned with a
//   single-cycle strobe.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_we           1 = write, 0 = read
//   req_addr         row address
//   req_wdata        write data
//   rsp_valid        one-cycle read-data strobe
//   rsp_rdata        read data, held until the next read capture
//   wwl, rwl         one-hot write / read wordlines
//   wbl              write bitline data (0 outside write states)
//   wr_assist        feedback-cut write assist
//   pre_en           read-bitline precharge
//   sense_en         read sense strobe (last read-wordline cycle)
//   rbl_in           sensed read bitlines from the array
//   busy             controller not idle
//   wr_err           (SRAM_CTRL_WRVERIFY_EN only) write-verify miscompare pulse
//
// Optional feature
//   SRAM_CTRL_WRVERIFY_EN: every write is followed by a read-back of the same
//   row (PRE -> RWL -> VCHK). wr_err pulses in VCHK when the read-back data
//   differs from the written data.

module sram10t_access_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int PRE_CYC  = 2,
  parameter int WL_CYC   = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic [2**ADDR_W-1:0] wwl,
  output logic [2**ADDR_W-1:0] rwl,
  output logic [DATA_W-1:0]    wbl,
  output logic                 wr_assist,
  output logic                 pre_en,
  output logic                 sense_en,
  input  logic [DATA_W-1:0]    rbl_in,
`ifdef SRAM_CTRL_WRVERIFY_EN
  output logic                 wr_err,
`endif
  output logic                 busy
);

  localparam int ROWS  = 2**ADDR_W;
  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LD   = CNT_W'(WL_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_RWL,
    S_RESP,
    S_WSETUP,
    S_WWL,
    S_WHOLD
`ifdef SRAM_CTRL_WRVERIFY_EN
    , S_VCHK
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]  addr_r;
  logic               we_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [ROWS-1:0]    row_oh;
  logic               accept;
  logic               cnt_done;
`ifdef SRAM_CTRL_WRVERIFY_EN
  logic [DATA_W-1:0]  vdata_r;
`endif

  assign accept   = (state == S_IDLE) && req_valid;
  assign cnt_done = (cnt == '0);

  // Next-state and phase counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            state_nxt = S_WSETUP;
          end else begin
            state_nxt = S_PRE;
            cnt_nxt   = PRE_LD;
          end
        end
      end
      S_PRE: begin
        if (cnt_done) begin
          state_nxt = S_RWL;
          cnt_nxt   = WL_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RWL: begin
        if (cnt_done) begin
`ifdef SRAM_CTRL_WRVERIFY_EN
          // A read phase entered from a write is the verify read-back.
          state_nxt = we_r ? S_VCHK : S_RESP;
`else
          state_nxt = S_RESP;
`endif
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RESP: state_nxt = S_IDLE;
      S_WSETUP: begin
        state_nxt = S_WWL;
        cnt_nxt   = WL_LD;
      end
      S_WWL: begin
        if (cnt_done) begin
          if (HOLD_CYC > 0) begin
            state_nxt = S_WHOLD;
            cnt_nxt   = HOLD_LD;
          end else begin
`ifdef SRAM_CTRL_WRVERIFY_EN
            state_nxt = S_PRE;
            cnt_nxt   = PRE_LD;
`else
            state_nxt = S_IDLE;
`endif
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_WHOLD: begin
        if (cnt_done) begin
`ifdef SRAM_CTRL_WRVERIFY_EN
          state_nxt = S_PRE;
          cnt_nxt   = PRE_LD;
`else
          state_nxt = S_IDLE;
`endif
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
`ifdef SRAM_CTRL_WRVERIFY_EN
      S_VCHK: state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if ((state == S_RWL) && cnt_done && !we_r) begin
        rsp_rdata <= rbl_in;
      end
    end
  end

  // Request latch (data only, no reset: every consumer is gated by state)
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_r  <= req_addr;
      we_r    <= req_we;
      wdata_r <= req_wdata;
    end
`ifdef SRAM_CTRL_WRVERIFY_EN
    if ((state == S_RWL) && cnt_done && we_r) begin
      vdata_r <= rbl_in;
    end
`endif
  end

  // Array-side outputs decoded from state
  always_comb begin
    row_oh         = '0;
    row_oh[addr_r] = 1'b1;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    wwl            = '0;
    rwl            = '0;
    wbl            = '0;
    wr_assist      = 1'b0;
    pre_en         = 1'b0;
    sense_en       = 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
    wr_err         = 1'b0;
`endif
    unique case (state)
      S_IDLE:  req_ready = ~rst;
      S_PRE:   pre_en    = 1'b1;
      S_RWL: begin
        rwl      = row_oh;
        sense_en = cnt_done;
      end
      S_RESP:  rsp_valid = 1'b1;
      S_WSETUP, S_WHOLD: begin
        wbl       = wdata_r;
        wr_assist = 1'b1;
      end
      S_WWL: begin
        wbl       = wdata_r;
        wr_assist = 1'b1;
        wwl       = row_oh;
      end
`ifdef SRAM_CTRL_WRVERIFY_EN
      S_VCHK:  wr_err = (vdata_r != wdata_r);
`endif
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
